// File: rtl/one_hot_to_bin_pipe.sv
// Registered, handshaked one-hot to binary encoder with zero/multi-hot flags and a saturating error counter.
// Optional build macro: ONEHOT_PRIORITY_EN (multi-hot inputs encode to their lowest set bit).
module one_hot_to_bin_pipe #(
    parameter int ORDER     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                                CLK,
    input  logic                                RSTN,
    input  logic [(1 << ORDER)-1:0]             ONE_HOT,
    input  logic [((ORDER > 1) ? ORDER : 1)-1:0] DEFAULT,
    input  logic                                IN_VALID,
    output logic                                IN_READY,
    output logic [((ORDER > 1) ? ORDER : 1)-1:0] BIN,
    output logic                                ZERO_HOT,
    output logic                                MULTI_HOT,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic [CNT_WIDTH-1:0]                ERR_COUNT,
    input  logic                                ERR_CLEAR
);

    localparam int WIDTH = 1 << ORDER;
    localparam int BW    = (ORDER > 1) ? ORDER : 1;

    logic             accept;
    logic             zero_hot_c;
    logic             multi_hot_c;
    logic             err_c;
    logic             cnt_sat;
    logic [WIDTH-1:0] low_cleared;
    logic [BW-1:0]    idx_c;
    logic [BW-1:0]    bin_c;

    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;

    // Clearing the lowest set bit leaves something behind only when two or more bits were set.
    assign low_cleared = ONE_HOT & (ONE_HOT - WIDTH'(1));
    assign zero_hot_c  = ~|ONE_HOT;
    assign multi_hot_c = |low_cleared;
    assign err_c       = zero_hot_c || multi_hot_c;
    assign cnt_sat     = &ERR_COUNT;

    always_comb begin
        idx_c = '0;
`ifdef ONEHOT_PRIORITY_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (ONE_HOT[i]) begin
                idx_c = BW'(i);
            end
        end
`else
        for (int i = 0; i < WIDTH; i++) begin
            if (ONE_HOT[i]) begin
                idx_c = idx_c | BW'(i);
            end
        end
`endif
    end

`ifdef ONEHOT_PRIORITY_EN
    assign bin_c = zero_hot_c ? DEFAULT : idx_c;
`else
    assign bin_c = err_c ? DEFAULT : idx_c;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            OUT_VALID <= 1'b0;
            BIN       <= '0;
            ZERO_HOT  <= 1'b0;
            MULTI_HOT <= 1'b0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            BIN       <= bin_c;
            ZERO_HOT  <= zero_hot_c;
            MULTI_HOT <= multi_hot_c;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

    // Clear beats a coincident erroneous accept; the count sticks at all-ones.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ERR_COUNT <= '0;
        end else if (ERR_CLEAR) begin
            ERR_COUNT <= '0;
        end else if (accept && err_c && !cnt_sat) begin
            ERR_COUNT <= ERR_COUNT + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/one_hot_to_bin_pipe.md
# one_hot_to_bin_pipe

Registered, handshaked one-hot to binary encoder with any power-of-two width and error accounting. Used in the cache datapath wherever way-hit or victim vectors must become a way index across a pipeline boundary. It replaces the fixed-order combinational converter:
- any `ORDER` up to 6;
- valid/ready flow control;
- zero-hot and multi-hot classification;
- a saturating error counter.

## Interface
Parameters
- `ORDER`, default 2: log2 of input width, legal 0..6.
- `CNT_WIDTH`, default 8: error counter width, legal 1..32.
- `WIDTH` (localparam) = `1 << ORDER`.
- `BW` (localparam) = `max(ORDER,1)`.

Ports
- `CLK`  in  1: clock. One clock domain only.
- `RSTN`  in  1: reset, synchronous, active-low.
- `ONE_HOT`  in  `WIDTH`: vector to encode.
- `DEFAULT`  in  `BW`: index emitted when the input is not exactly one-hot.
- `IN_VALID`  in  1: `ONE_HOT`/`DEFAULT` valid.
- `IN_READY`  out  1: block accepts input this cycle.
- `BIN`  out  `BW`: encoded index.
- `ZERO_HOT`  out  1: registered; the accepted input had no bits set.
- `MULTI_HOT`  out  1: registered; the accepted input had more than one bit set.
- `OUT_VALID`  out  1: `BIN`/`ZERO_HOT`/`MULTI_HOT` valid.
- `OUT_READY`  in  1: downstream accepts.
- `ERR_COUNT`  out  `CNT_WIDTH`: number of accepted inputs with `ZERO_HOT` or `MULTI_HOT` set.
- `ERR_CLEAR`  in  1: synchronous clear of `ERR_COUNT`.

## Operation
- Single output register stage with handshake.
  - `IN_READY = !OUT_VALID || OUT_READY`. This is combinational and is the only in-to-out combinational path.
  - An input is accepted on a rising edge of `CLK` with `IN_VALID && IN_READY`. The output register loads `BIN`, `ZERO_HOT`, `MULTI_HOT` and sets `OUT_VALID`.
  - On `OUT_READY && OUT_VALID` with no new accept, `OUT_VALID` clears. `BIN` and the flags hold their last value.
  - While `OUT_VALID && !OUT_READY`, outputs are stable and `IN_READY = 0`.
- Encoding of an accepted input:
  - Exactly one bit k set: `BIN = k`, both flags 0.
  - Zero bits set: `BIN = DEFAULT`, `ZERO_HOT = 1`.
  - More than one bit set: `BIN = DEFAULT` (see Configuration), `MULTI_HOT = 1`.
- `ORDER = 0`: `ONE_HOT = 1` gives `BIN = 0`. `ONE_HOT = 0` gives `DEFAULT` with `ZERO_HOT`. `MULTI_HOT` is never set.
- Encoding is generic (loop/reduction) and is not a per-order case table. Popcount classification is needed only as zero / one / more-than-one.
- `ERR_COUNT`:
  - Increments by 1 on each accept whose `ZERO_HOT` or `MULTI_HOT` result is 1.
  - Saturates at all-ones and does not wrap.
  - `ERR_CLEAR` has priority: when clear and an erroneous accept fall in the same cycle, the count becomes 0, not 1.

## Timing
- Latency is 1 cycle from accept to `OUT_VALID`. Full throughput is 1 transfer per cycle while `OUT_READY = 1`.
- Reset (`RSTN = 0` at a `CLK` edge) gives:
  - `OUT_VALID = 0`, `BIN = 0`, `ZERO_HOT = 0`, `MULTI_HOT = 0`, `ERR_COUNT = 0`.
  - `IN_READY` is therefore 1 during and after reset.
- Reset mid-transfer drops the held output. No accept occurs on a reset edge, even with `IN_VALID = 1`.
- Simultaneous pop and push (`OUT_VALID && OUT_READY && IN_VALID`) loads the new result, and `OUT_VALID` stays 1 (back-to-back).
- `ONE_HOT` and `DEFAULT` are sampled only on accept. Changes while `IN_READY = 0` have no effect.
- `ERR_CLEAR` applies on its edge regardless of the handshake.

## Configuration
- `ONEHOT_PRIORITY_EN` defined:
  - A multi-hot input encodes to the index of its lowest set bit, e.g. `8'b0010_1000` gives 3.
  - `MULTI_HOT` and the `ERR_COUNT` increment still occur.
- Not defined:
  - A multi-hot input gives `BIN = DEFAULT`.
- Zero-hot behaviour is identical in both builds.

## Test plan
All scenarios use `ORDER = 3` and `CNT_WIDTH = 2` unless noted.

- **Reset**: hold `RSTN = 0` for 2 cycles with `IN_VALID = 1`, `ONE_HOT = 8'h04` → all outputs 0 and `IN_READY = 1`. Release reset → `BIN = 2` one cycle later.
- **Streaming**: `OUT_READY = 1`; sweep `ONE_HOT = 1 << k` for k = 0..7 on consecutive cycles → `BIN` = 0..7 on consecutive cycles, `OUT_VALID` continuously 1, flags 0.
- **Backpressure**: accept `8'h80`, hold `OUT_READY = 0` for 3 cycles while `ONE_HOT` changes → `BIN = 7` stable and `IN_READY = 0`. Raise `OUT_READY` with `8'h01` valid → next cycle `BIN = 0`.
- **Errors**: `DEFAULT = 5`, inputs `8'h00` then `8'h28`.
  - `8'h00` → `BIN = 5`, `ZERO_HOT = 1`.
  - `8'h28` → `MULTI_HOT = 1`, with `BIN = 5` (no macro) or `BIN = 3` (`ONEHOT_PRIORITY_EN`).
- **Counter**: present 5 erroneous inputs → `ERR_COUNT` reads 1, 2, 3, 3, 3 (saturated). Assert `ERR_CLEAR` in the same cycle as an erroneous accept → `ERR_COUNT = 0`.
- **ORDER = 0**: `ONE_HOT = 1` → `BIN = 0`, flags 0. `ONE_HOT = 0` with `DEFAULT = 1` → `BIN = 1`, `ZERO_HOT = 1`, `ERR_COUNT` increments.
